// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back/write-allocate data cache between an 8-bit CPU port
// and a 32-bit-block memory; stalls the CPU on a miss while it writes back the victim and refills.
module dcache_controller #(
   parameter int INDEX_W = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        READ,
   input  logic        WRITE,
   input  logic [7:0]  ADDRESS,
   input  logic [7:0]  WRITEDATA,
   output logic [7:0]  READDATA,
   output logic        BUSYWAIT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [5:0]  MEM_ADDRESS,
   output logic [31:0] MEM_WRITEDATA,
   input  logic [31:0] MEM_READDATA,
   input  logic        MEM_BUSYWAIT
);
   localparam int TAG_W = 6 - INDEX_W;
   localparam int N = 1 << INDEX_W;
   localparam logic [1:0] IDLE = 2'd0, WRITEBACK = 2'd1, REFILL = 2'd2, ALLOCATE = 2'd3;

   logic [1:0] state;
   logic [31:0] data [N];
   logic [TAG_W-1:0] tags [N];
   logic [N-1:0] valid, dirty;
   logic [5:0] miss_addr;
   logic [7:0] read_q, sel;
   logic [TAG_W-1:0] tag, m_tag;
   logic [INDEX_W-1:0] index, m_index;
   logic [1:0] offset;
   logic hit, idle, request, write_hit;

   assign {tag, index, offset} = ADDRESS;
   // The missing block address is latched so a dropped or changed request cannot redirect the refill.
   assign {m_tag, m_index} = miss_addr;
   assign hit = valid[index] && tags[index] == tag;
   assign sel = data[index][{offset, 3'b000} +: 8];
   assign idle = state == IDLE;
   assign request = READ | WRITE;
   assign write_hit = idle & WRITE & hit;

   assign BUSYWAIT = ~RESET & ((request & ~hit) | ~idle);
   assign READDATA = READ & hit & idle ? sel : read_q;
   assign MEM_WRITE = state == WRITEBACK;
   assign MEM_READ = state == REFILL;
   assign MEM_ADDRESS = MEM_WRITE ? {tags[m_index], m_index} : MEM_READ ? miss_addr : 6'd0;
   assign MEM_WRITEDATA = MEM_WRITE ? data[m_index] : 32'd0;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
         miss_addr <= '0;
         read_q <= '0;
      end else begin
         if (READ & hit & idle) read_q <= sel;
         case (state)
            IDLE:
               if (request & ~hit) begin
                  miss_addr <= ADDRESS[7:2];
                  state <= valid[index] & dirty[index] ? WRITEBACK : REFILL;
               end else if (write_hit) dirty[index] <= 1'b1;
            WRITEBACK: if (!MEM_BUSYWAIT) state <= REFILL;
            REFILL: if (!MEM_BUSYWAIT) state <= ALLOCATE;
            ALLOCATE: begin
               valid[m_index] <= 1'b1;
               dirty[m_index] <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Data and tag arrays carry no reset; valid bits alone qualify them.
   always_ff @(posedge CLK) begin
      if (state == ALLOCATE) begin
         data[m_index] <= MEM_READDATA;
         tags[m_index] <= m_tag;
      end else if (write_hit) data[index][{offset, 3'b000} +: 8] <= WRITEDATA;
   end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed vector table against a latency-5 block memory model,
// plus a hand sequence for asynchronous reset during refill.
module tb_dcache_controller;
   localparam int LAT = 5;
   logic CLK = 1'b0, RESET = 1'b1, READ = 1'b0, WRITE = 1'b0;
   logic [7:0] ADDRESS = 8'd0, WRITEDATA = 8'd0, READDATA;
   logic BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
   logic [5:0] MEM_ADDRESS;
   logic [31:0] MEM_WRITEDATA, MEM_READDATA;

   dcache_controller #(.INDEX_W(3)) dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
      .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem [64] = '{0: 32'h03020100, 1: 32'hDDCCBBAA, 9: 32'h44332211, 16: 32'h0D0C0B0A,
                             33: 32'h77665544, 63: 32'h89ABCDEF, default: 32'h0};
   logic [31:0] rdata = 32'd0;
   int cnt = 0, nrd = 0, nwr = 0;
   logic [5:0] last_raddr = 6'd0, last_waddr = 6'd0;
   logic [31:0] last_wdata = 32'd0;
   logic both = 1'b0;

   assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && cnt != LAT;
   assign MEM_READDATA = rdata;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) cnt <= 0;
      else if (MEM_READ | MEM_WRITE) begin
         cnt <= cnt == LAT ? 0 : cnt + 1;
         if (MEM_READ & MEM_WRITE) both <= 1'b1;
         if (!MEM_BUSYWAIT && MEM_READ) begin
            rdata <= mem[MEM_ADDRESS];
            nrd <= nrd + 1;
            last_raddr <= MEM_ADDRESS;
         end
         if (!MEM_BUSYWAIT && MEM_WRITE) begin
            mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            nwr <= nwr + 1;
            last_waddr <= MEM_ADDRESS;
            last_wdata <= MEM_WRITEDATA;
         end
      end else cnt <= 0;
   end

   typedef struct {
      logic rd;
      logic [7:0] addr, wdata, rdata;
      int stall, nr, nw;
      logic [5:0] raddr, waddr;
      logic [31:0] wblk;
   } vec_t;

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic access(input logic rd, input logic [7:0] a, input logic [7:0] wd,
                         output int n, output logic [7:0] rdv);
      @(negedge CLK);
      READ = rd;
      WRITE = !rd;
      ADDRESS = a;
      WRITEDATA = wd;
      #1;
      n = 0;
      while (BUSYWAIT && n < 200) begin
         @(negedge CLK);
         #1;
         n++;
      end
      rdv = READDATA;
      @(posedge CLK);
      #1;
      READ = 1'b0;
      WRITE = 1'b0;
   endtask

   initial begin
      vec_t v [12];
      int n, r0, w0, k;
      logic [7:0] rdv;
      v[0]  = '{1'b1, 8'h04, 8'h00, 8'hAA, 8,  1, 0, 6'h01, 6'h00, 32'h0};
      v[1]  = '{1'b1, 8'h07, 8'h00, 8'hDD, 0,  0, 0, 6'h00, 6'h00, 32'h0};
      v[2]  = '{1'b0, 8'h05, 8'h55, 8'h00, 0,  0, 0, 6'h00, 6'h00, 32'h0};
      v[3]  = '{1'b1, 8'h05, 8'h00, 8'h55, 0,  0, 0, 6'h00, 6'h00, 32'h0};
      v[4]  = '{1'b1, 8'h24, 8'h00, 8'h11, 14, 1, 1, 6'h09, 6'h01, 32'hDDCC55AA};
      v[5]  = '{1'b0, 8'h40, 8'h7E, 8'h00, 8,  1, 0, 6'h10, 6'h00, 32'h0};
      v[6]  = '{1'b1, 8'h40, 8'h00, 8'h7E, 0,  0, 0, 6'h00, 6'h00, 32'h0};
      v[7]  = '{1'b1, 8'h43, 8'h00, 8'h0D, 0,  0, 0, 6'h00, 6'h00, 32'h0};
      v[8]  = '{1'b1, 8'hFF, 8'h00, 8'h89, 8,  1, 0, 6'h3F, 6'h00, 32'h0};
      v[9]  = '{1'b1, 8'h24, 8'h00, 8'h11, 0,  0, 0, 6'h00, 6'h00, 32'h0};
      v[10] = '{1'b1, 8'h05, 8'h00, 8'h55, 8,  1, 0, 6'h01, 6'h00, 32'h0};
      v[11] = '{1'b1, 8'h00, 8'h00, 8'h00, 14, 1, 1, 6'h00, 6'h10, 32'h0D0C0B7E};

      #2;
      check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
      check("reset_mem_write", {31'd0, MEM_WRITE}, 32'd0);
      check("reset_mem_address", {26'd0, MEM_ADDRESS}, 32'd0);
      check("reset_mem_writedata", MEM_WRITEDATA, 32'd0);
      check("reset_readdata", {24'd0, READDATA}, 32'd0);
      repeat (2) @(negedge CLK);
      RESET = 1'b0;

      for (int i = 0; i < 12; i++) begin
         r0 = nrd;
         w0 = nwr;
         access(v[i].rd, v[i].addr, v[i].wdata, n, rdv);
         check($sformatf("v%0d_stall_cycles", i), n, v[i].stall);
         check($sformatf("v%0d_mem_reads", i), nrd - r0, v[i].nr);
         check($sformatf("v%0d_mem_writes", i), nwr - w0, v[i].nw);
         if (v[i].rd) check($sformatf("v%0d_readdata", i), {24'd0, rdv}, {24'd0, v[i].rdata});
         if (v[i].nr != 0) check($sformatf("v%0d_refill_addr", i), {26'd0, last_raddr}, {26'd0, v[i].raddr});
         if (v[i].nw != 0) begin
            check($sformatf("v%0d_wb_addr", i), {26'd0, last_waddr}, {26'd0, v[i].waddr});
            check($sformatf("v%0d_wb_data", i), last_wdata, v[i].wblk);
         end
      end

      @(negedge CLK);
      READ = 1'b1;
      ADDRESS = 8'h84;
      k = 0;
      while (!MEM_READ && k < 50) begin
         @(negedge CLK);
         k++;
      end
      check("rst_refill_started", {31'd0, MEM_READ}, 32'd1);
      check("rst_refill_addr", {26'd0, MEM_ADDRESS}, 32'h21);
      #2 RESET = 1'b1;
      #1;
      check("rst_async_mem_read", {31'd0, MEM_READ}, 32'd0);
      check("rst_async_mem_write", {31'd0, MEM_WRITE}, 32'd0);
      check("rst_async_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("rst_async_readdata", {24'd0, READDATA}, 32'd0);
      READ = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      r0 = nrd;
      w0 = nwr;
      access(1'b1, 8'h04, 8'h00, n, rdv);
      check("post_rst_stall_cycles", n, 8);
      check("post_rst_mem_reads", nrd - r0, 1);
      check("post_rst_mem_writes", nwr - w0, 0);
      check("post_rst_readdata", {24'd0, rdv}, 32'hAA);
      check("strobes_exclusive", {31'd0, both}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
